// File: rtl/pulse_meter.sv
// pulse_meter: measures the width (in clock cycles) of each pulse on 'in' and offers it over dav/rfd.
// Optional sticky overrun flag 'ovr' is built only when PULSE_METER_OVR_EN is defined.
module pulse_meter #(
   parameter int unsigned W = 8
) (
   input  logic         clock,
   input  logic         reset_,
   input  logic         in,
   input  logic         rfd,
   output logic         dav,
   output logic [W-1:0] len,
   output logic         busy
`ifdef PULSE_METER_OVR_EN
   ,
   output logic         ovr
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      COUNT,
      OFFER,
      DONE
   } state_t;

   state_t star;
   logic   in_prev;
   logic   rise;
   logic   len_max;

   assign rise    = in & ~in_prev;
   assign len_max = &len;

   // In COUNT, busy=0 marks a finished pulse still waiting for rfd=1 before dav may rise.
   always_ff @(posedge clock) begin
      if (!reset_) begin
         star    <= IDLE;
         dav     <= 1'b0;
         busy    <= 1'b0;
         len     <= '0;
         in_prev <= 1'b1;
      end else begin
         in_prev <= in;
         case (star)
            IDLE: begin
               if (rise) begin
                  len  <= W'(1);
                  busy <= 1'b1;
                  star <= COUNT;
               end
            end
            COUNT: begin
               if (busy && in) begin
                  if (!len_max) len <= len + W'(1);
               end else begin
                  busy <= 1'b0;
                  if (rfd) begin
                     dav  <= 1'b1;
                     star <= OFFER;
                  end
               end
            end
            OFFER: begin
               if (!rfd) begin
                  dav  <= 1'b0;
                  star <= DONE;
               end
            end
            DONE: begin
               if (rfd) star <= IDLE;
            end
            default: star <= IDLE;
         endcase
      end
   end

`ifdef PULSE_METER_OVR_EN
   always_ff @(posedge clock) begin
      if (!reset_) begin
         ovr <= 1'b0;
      end else if (star == IDLE && rise) begin
         ovr <= 1'b0;
      end else if ((star == OFFER || star == DONE) && rise) begin
         ovr <= 1'b1;
      end else if (star == COUNT && busy && in && len_max) begin
         ovr <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: W=8 and W=4 instances share stimulus, checked each cycle against a pulse-level model.
module tb_pulse_meter;
   localparam int NI = 2;

   logic       clock = 1'b0;
   logic       reset_;
   logic       in;
   logic       rfd;
   logic       dav8, busy8, dav4, busy4;
   logic [7:0] len8;
   logic [3:0] len4;
`ifdef PULSE_METER_OVR_EN
   logic       ovr8, ovr4;
   bit         m_ovr[NI];
`endif

   int vectors     = 0;
   int miscompares = 0;

   // model: phase 0 idle, 1 measuring, 2 offered, 3 taken; cnt is unbounded, len = min(cnt, cap)
   int m_phase[NI];
   int m_cnt[NI];
   bit m_ended[NI];
   bit m_prev;
   int m_cap[NI] = '{255, 15};

   always #5 clock = ~clock;

   pulse_meter #(.W(8)) dut (
      .clock(clock), .reset_(reset_), .in(in), .rfd(rfd),
      .dav(dav8), .len(len8), .busy(busy8)
`ifdef PULSE_METER_OVR_EN
      , .ovr(ovr8)
`endif
   );

   pulse_meter #(.W(4)) dut4 (
      .clock(clock), .reset_(reset_), .in(in), .rfd(rfd),
      .dav(dav4), .len(len4), .busy(busy4)
`ifdef PULSE_METER_OVR_EN
      , .ovr(ovr4)
`endif
   );

   task automatic model_step(input bit i, input bit r, input bit rs);
      bit rise;
      rise = i && !m_prev;
      for (int k = 0; k < NI; k++) begin
         if (!rs) begin
            m_phase[k] = 0;
            m_cnt[k]   = 0;
            m_ended[k] = 1'b0;
`ifdef PULSE_METER_OVR_EN
            m_ovr[k]   = 1'b0;
`endif
         end else begin
            case (m_phase[k])
               0: if (rise) begin
                  m_cnt[k]   = 1;
                  m_ended[k] = 1'b0;
                  m_phase[k] = 1;
`ifdef PULSE_METER_OVR_EN
                  m_ovr[k]   = 1'b0;
`endif
               end
               1: if (!m_ended[k] && i) begin
                  m_cnt[k]++;
`ifdef PULSE_METER_OVR_EN
                  if (m_cnt[k] > m_cap[k]) m_ovr[k] = 1'b1;
`endif
               end else begin
                  m_ended[k] = 1'b1;
                  if (r) m_phase[k] = 2;
               end
               2: begin
`ifdef PULSE_METER_OVR_EN
                  if (rise) m_ovr[k] = 1'b1;
`endif
                  if (!r) m_phase[k] = 3;
               end
               default: begin
`ifdef PULSE_METER_OVR_EN
                  if (rise) m_ovr[k] = 1'b1;
`endif
                  if (r) m_phase[k] = 0;
               end
            endcase
         end
      end
      m_prev = rs ? i : 1'b1;
   endtask

   function automatic int exp_len(input int k);
      return (m_cnt[k] > m_cap[k]) ? m_cap[k] : m_cnt[k];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_all();
      check("dav8",  32'(dav8),  32'(m_phase[0] == 2));
      check("busy8", 32'(busy8), 32'(m_phase[0] == 1 && !m_ended[0]));
      check("len8",  32'(len8),  exp_len(0));
      check("dav4",  32'(dav4),  32'(m_phase[1] == 2));
      check("busy4", 32'(busy4), 32'(m_phase[1] == 1 && !m_ended[1]));
      check("len4",  32'(len4),  exp_len(1));
`ifdef PULSE_METER_OVR_EN
      check("ovr8",  32'(ovr8),  32'(m_ovr[0]));
      check("ovr4",  32'(ovr4),  32'(m_ovr[1]));
`endif
   endtask

   task automatic cycle(input bit i, input bit r, input bit rs);
      in     = i;
      rfd    = r;
      reset_ = rs;
      @(posedge clock);
      model_step(i, r, rs);
      #1;
      check_all();
   endtask

   initial begin
      bit ri, rr, rs;
      in = 1'b0; rfd = 1'b1; reset_ = 1'b0;
      cycle(0, 1, 0); cycle(0, 1, 0);
      check("rst_len", 32'(len8), 0);
      check("rst_dav", 32'(dav8), 0);

      // 5-cycle pulse, then held offer with a lost 3-cycle pulse
      cycle(0, 1, 1);
      repeat (5) cycle(1, 1, 1);
      check("t1_busy", 32'(busy8), 1);
      cycle(0, 1, 1);
      check("t1_len", 32'(len8), 5);
      check("t1_dav", 32'(dav8), 1);
      repeat (3) cycle(1, 1, 1);
      cycle(0, 1, 1);
      check("t4_len", 32'(len8), 5);
      check("t4_dav", 32'(dav8), 1);
`ifdef PULSE_METER_OVR_EN
      check("t4_ovr", 32'(ovr8), 1);
`endif
      cycle(0, 0, 1);
      check("t2_drop", 32'(dav8), 0);
      cycle(0, 1, 1);

      // saturation on the W=4 instance
      repeat (20) cycle(1, 1, 1);
      cycle(0, 1, 1);
      check("t3_len4", 32'(len4), 15);
      check("t3_len8", 32'(len8), 20);
`ifdef PULSE_METER_OVR_EN
      check("t3_ovr4", 32'(ovr4), 1);
      check("t3_ovr8", 32'(ovr8), 0);
`endif
      cycle(0, 0, 1); cycle(0, 1, 1);

      // pulse ends while rfd=0: wait in COUNT, extra highs not counted
      cycle(0, 1, 1);
      repeat (4) cycle(1, 1, 1);
      cycle(0, 0, 1); cycle(1, 0, 1); cycle(1, 0, 1);
      cycle(0, 1, 1);
      check("wait_len", 32'(len8), 4);
      cycle(0, 0, 1); cycle(0, 1, 1);

      // in high at reset release, 1-cycle pulse, back-to-back pulse
      cycle(1, 1, 0);
      repeat (3) cycle(1, 1, 1);
      check("hi_rel_busy", 32'(busy8), 0);
      cycle(0, 1, 1); cycle(1, 1, 1);
      cycle(0, 1, 1);
      check("one_len", 32'(len8), 1);
      cycle(0, 0, 1); cycle(0, 1, 1);
      cycle(1, 1, 1); cycle(1, 1, 1); cycle(0, 1, 1);
      check("b2b_len", 32'(len8), 2);
      cycle(0, 0, 1); cycle(0, 1, 1);

      // reset during COUNT and during OFFER
      cycle(0, 1, 1);
      repeat (3) cycle(1, 1, 1);
      check("mid_len", 32'(len8), 3);
      cycle(1, 1, 0);
      check("mid_rst_len", 32'(len8), 0);
      cycle(0, 1, 1);
      repeat (2) cycle(1, 1, 1);
      cycle(0, 1, 1);
      cycle(0, 1, 0);
      check("off_rst_dav", 32'(dav8), 0);
      cycle(0, 1, 1);

      // randomized run with persistent levels
      ri = 1'b0; rr = 1'b1;
      repeat (3000) begin
         if ($urandom_range(3) == 0) ri = ~ri;
         if ($urandom_range(2) == 0) rr = ~rr;
         rs = ($urandom_range(299) != 0);
         cycle(ri, rr, rs);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
